// File: rtl/noc_send_arbiter_if.sv
// Request/send bundle between local requesters and the TDMA send arbiter.
// The master side is the requester group. The slave side is the arbiter.
interface noc_send_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [8*NUM_REQ-1:0]  req_addr;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_enable;
    logic [NUM_REQ-1:0]    req_ack;
    logic [NUM_REQ-1:0]    grant;
    logic                  send_valid;
    logic [7:0]            send_addr;
    logic [31:0]           send_data;
    logic                  busy;
    logic [15:0]           pkt_count;

    modport master (
        output req_valid, req_addr, req_data, req_enable,
        input  req_ack, grant, send_valid, send_addr, send_data, busy, pkt_count
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_enable,
        output req_ack, grant, send_valid, send_addr, send_data, busy, pkt_count
    );
endinterface

// File: rtl/noc_send_arbiter.sv
// Round-robin arbiter that shares the TDMA network send port between local requesters.
// Each packet is held on the port for HOLD_CYCLES cycles, then acknowledged in a one-cycle gap.
module noc_send_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset,
    noc_send_arbiter_if.slave   bus
);
    localparam int                     PTR_W = $clog2(NUM_REQ);
    localparam int unsigned            NREQ  = NUM_REQ;
    localparam logic [PTR_W-1:0]       LAST  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     winner_q, winner_d;
    logic [7:0]           hold_cnt_q, hold_cnt_d;
    logic                 send_valid_q, send_valid_d;
    logic [7:0]           send_addr_q, send_addr_d;
    logic [31:0]          send_data_q, send_data_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic                 busy_q, busy_d;
    logic [15:0]          pkt_count_q, pkt_count_d;

    logic [NUM_REQ-1:0]   eligible;
    logic [PTR_W-1:0]     sel;
    logic [PTR_W-1:0]     idx;
    logic                 found;

    // First eligible requester at or after rr_ptr, wrapping around.
    always_comb begin
        eligible = bus.req_valid & bus.req_enable;
        sel      = '0;
        idx      = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PTR_W'((32'(rr_ptr_q) + i) % NREQ);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        winner_d     = winner_q;
        hold_cnt_d   = hold_cnt_q;
        send_valid_d = send_valid_q;
        send_addr_d  = send_addr_q;
        send_data_d  = send_data_q;
        grant_d      = grant_q;
        req_ack_d    = '0;
        busy_d       = busy_q;
        pkt_count_d  = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = SEND;
                    winner_d      = sel;
                    send_addr_d   = bus.req_addr[8*sel +: 8];
                    send_data_d   = bus.req_data[32*sel +: 32];
                    grant_d       = '0;
                    grant_d[sel]  = 1'b1;
                    send_valid_d  = 1'b1;
                    busy_d        = 1'b1;
                    hold_cnt_d    = 8'(HOLD_CYCLES - 1);
                end
            end
            SEND: begin
                if (hold_cnt_q != 8'd0) begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end else begin
                    // Completion effects are registered on entry to GAP so they appear during it.
                    state_d             = GAP;
                    send_valid_d        = 1'b0;
                    grant_d             = '0;
                    req_ack_d[winner_q] = 1'b1;
                    pkt_count_d         = pkt_count_q + 16'd1;
                    rr_ptr_d            = (winner_q == LAST) ? '0 : winner_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            winner_q     <= '0;
            hold_cnt_q   <= '0;
            send_valid_q <= 1'b0;
            send_addr_q  <= '0;
            send_data_q  <= '0;
            grant_q      <= '0;
            req_ack_q    <= '0;
            busy_q       <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            winner_q     <= winner_d;
            hold_cnt_q   <= hold_cnt_d;
            send_valid_q <= send_valid_d;
            send_addr_q  <= send_addr_d;
            send_data_q  <= send_data_d;
            grant_q      <= grant_d;
            req_ack_q    <= req_ack_d;
            busy_q       <= busy_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign bus.req_ack    = req_ack_q;
    assign bus.grant      = grant_q;
    assign bus.send_valid = send_valid_q;
    assign bus.send_addr  = send_addr_q;
    assign bus.send_data  = send_data_q;
    assign bus.busy       = busy_q;
    assign bus.pkt_count  = pkt_count_q;
endmodule
